// File: rtl/sad_accumulator.sv
// Multi-lane sum-of-absolute-differences engine, accumulated per BLOCK_LEN beats.
// Define SAD_SIGNED_EN to treat lane operands as two's-complement (default unsigned).
module sad_accumulator #(
    parameter int DATA_W    = 8,
    parameter int LANES     = 4,
    parameter int BLOCK_LEN = 16,
    localparam int SUM_W    = DATA_W + $clog2(LANES) + $clog2(BLOCK_LEN)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [LANES*DATA_W-1:0] i_a_data,
    input  logic [LANES*DATA_W-1:0] i_b_data,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [SUM_W-1:0]        o_out_sad
);
    localparam int S2_W  = DATA_W + $clog2(LANES);
    localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLOCK_LEN - 1);

    logic                          w_stall, w_accept, w_last_in;
    logic [CNT_W-1:0]              r_cnt;
    logic [LANES-1:0][DATA_W-1:0]  w_diff, r_diff;
    logic [S2_W-1:0]               w_sum, r_s2_sum;
    logic [1:0]                    r_vld_pipe, r_last_pipe;
    logic                          r_first;
    logic [SUM_W-1:0]              r_acc, w_acc_next, r_out_sad;
    logic                          r_out_valid;

    // Only the output handshake can stall; everything upstream freezes together.
    assign w_stall     = r_out_valid && !i_out_ready;
    assign o_in_ready  = !w_stall;
    assign w_accept    = i_in_valid && !w_stall;
    assign w_last_in   = (r_cnt == CNT_MAX);
    assign o_out_valid = r_out_valid;
    assign o_out_sad   = r_out_sad;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            logic [DATA_W-1:0] w_a, w_b;
            logic              w_ge;
            assign w_a = i_a_data[g*DATA_W +: DATA_W];
            assign w_b = i_b_data[g*DATA_W +: DATA_W];
`ifdef SAD_SIGNED_EN
            assign w_ge = $signed(w_a) >= $signed(w_b);
`else
            assign w_ge = w_a >= w_b;
`endif
            // Modular DATA_W subtraction yields the exact magnitude in both modes.
            assign w_diff[g] = w_ge ? (w_a - w_b) : (w_b - w_a);
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++)
            w_sum = w_sum + S2_W'(r_diff[i]);
    end

    assign w_acc_next = (r_first ? '0 : r_acc) + SUM_W'(r_s2_sum);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_diff      <= '0;
            r_s2_sum    <= '0;
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
            r_first     <= 1'b1;
            r_acc       <= '0;
            r_out_sad   <= '0;
            r_out_valid <= 1'b0;
        end else if (!w_stall) begin
            if (w_accept)
                r_cnt <= w_last_in ? '0 : r_cnt + 1'b1;
            r_diff         <= w_diff;
            r_vld_pipe[0]  <= w_accept;
            r_last_pipe[0] <= w_accept && w_last_in;
            r_s2_sum       <= w_sum;
            r_vld_pipe[1]  <= r_vld_pipe[0];
            r_last_pipe[1] <= r_last_pipe[0];
            if (r_vld_pipe[1]) begin
                r_acc   <= w_acc_next;
                r_first <= r_last_pipe[1];
                if (r_last_pipe[1])
                    r_out_sad <= w_acc_next;
            end
            // Not stalled means any held result is being consumed this cycle.
            r_out_valid <= r_vld_pipe[1] && r_last_pipe[1];
        end
    end
endmodule

// File: tb/tb_sad_accumulator.sv
// Directed self-checking bench for sad_accumulator (default parameters).
module tb_sad_accumulator;
    localparam int DW = 8, L = 4, BL = 16;
    localparam int SW = DW + 2 + 4;

    logic          i_clk = 0, i_rst = 1, i_in_valid = 0, i_out_ready = 1;
    logic [L*DW-1:0] i_a_data = '0, i_b_data = '0;
    logic          o_in_ready, o_out_valid;
    logic [SW-1:0] o_out_sad;

    sad_accumulator #(.DATA_W(DW), .LANES(L), .BLOCK_LEN(BL)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_a_data(i_a_data), .i_b_data(i_b_data), .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready), .o_out_sad(o_out_sad));

    always #5 i_clk = ~i_clk;

    int n_chk = 0, n_err = 0;
    int cyc = 0, last_acc = 0, rise_cyc = 0;
    logic prev_ov = 0;
    logic [SW-1:0] q[$];

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_out_valid && !prev_ov) rise_cyc = cyc;
        prev_ov = o_out_valid;
        if (!i_rst && o_out_valid && i_out_ready) q.push_back(o_out_sad);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    task automatic beat(input logic [L*DW-1:0] a, input logic [L*DW-1:0] b);
        int n = 0;
        i_in_valid = 1; i_a_data = a; i_b_data = b;
        @(negedge i_clk);
        while (!o_in_ready && n < 50) begin n++; @(negedge i_clk); end
        if (n >= 50) chk("beat_timeout", 0, 1);
        last_acc = cyc;
        @(posedge i_clk); #1;
        i_in_valid = 0;
    endtask

    task automatic block(input logic [L*DW-1:0] a, input logic [L*DW-1:0] b);
        for (int j = 0; j < BL; j++) beat(a, b);
    endtask

    task automatic wait_res(input string tag, input logic [31:0] exp);
        int n = 0;
        while (q.size() == 0 && n < 40) begin @(posedge i_clk); #1; n++; end
        if (q.size() == 0) chk({tag, "_timeout"}, 0, 1);
        else chk(tag, q.pop_front(), exp);
    endtask

    task automatic do_reset();
        i_rst = 1; idle(2); i_rst = 0;
        @(negedge i_clk);
        chk("rst_ov", o_out_valid, 0);
        chk("rst_sad", o_out_sad, 0);
        chk("rst_rdy", o_in_ready, 1);
        @(posedge i_clk); #1;
    endtask

    initial begin
        do_reset();

        // Max magnitude plus latency from last accept to out_valid
        block(32'hFFFF_FFFF, 32'h0);
        wait_res("maxmag", 16320);
        chk("latency", rise_cyc - last_acc, 3);

        // Mixed lanes: (10,250),(250,10),(7,7),(0,1) and the swapped operands
        block({8'd0, 8'd7, 8'd250, 8'd10}, {8'd1, 8'd7, 8'd10, 8'd250});
        wait_res("mixed", 7696);
        block({8'd1, 8'd7, 8'd10, 8'd250}, {8'd0, 8'd7, 8'd250, 8'd10});
        wait_res("mixed_swap", 7696);

        // Backpressure across two back-to-back blocks
        i_out_ready = 0;
        fork
            begin
                block(32'h0101_0101, 32'h0);
                block(32'h0202_0202, 32'h0);
            end
            begin
                int n = 0;
                @(negedge i_clk);
                while (!o_out_valid && n < 60) begin n++; @(negedge i_clk); end
                chk("bp_seen", o_out_valid, 1);
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge i_clk);
                    chk("bp_rdy_low", o_in_ready, 0);
                    chk("bp_hold", o_out_sad, 64);
                end
                @(posedge i_clk); #1;
                i_out_ready = 1;
                @(negedge i_clk);
                chk("bp_rdy_high", o_in_ready, 1);
            end
        join
        wait_res("bp_first", 64);
        wait_res("bp_second", 128);

        // Ramp data, gap-free then with random bubbles: 4*(0+..+15) = 480
        for (int j = 0; j < BL; j++) beat({4{8'(j)}}, 32'h0);
        wait_res("ramp", 480);
        for (int j = 0; j < BL; j++) begin
            beat({4{8'(j)}}, 32'h0);
            idle($urandom_range(0, 2));
        end
        wait_res("ramp_gaps", 480);

        // Reset mid-block discards the partial block
        for (int j = 0; j < 7; j++) beat(32'hFFFF_FFFF, 32'h0);
        do_reset();
        block(32'h0101_0101, 32'h0);
        wait_res("post_rst", 64);

        // Signedness corner: 0x7F vs 0x80
        block(32'h7F7F_7F7F, 32'h8080_8080);
`ifdef SAD_SIGNED_EN
        wait_res("signed", 16320);
`else
        wait_res("unsigned", 64);
`endif

        idle(10);
        chk("no_extra", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1);
    end
endmodule
